// File: rtl/pueo_trig_gate_if.sv
// pueo_trig_gate_if
//   Bundles the level-two trigger control inputs and the gate/status outputs of
//   the trigger acceptance controller. Clock and reset are kept outside.
//   master : drives ce/run/trig/holdoff_len/evdone, observes gates and status.
//   slave  : the acceptance controller itself.
// Signals:
//   ce_i           clock enable shared with the level-two trigger
//   run_i          run enable level
//   trig_i         master trigger, single-cycle pulse
//   holdoff_len_i  holdoff length in ce ticks, minus one
//   evdone_i       single-cycle pulse, one event buffer freed
//   holdoff_o      holdoff gate
//   dead_o         dead gate
//   event_num_o    number of the most recently accepted event
//   outstanding_o  accepted events not yet freed
//   deadtime_o     saturating count of gated ce ticks while running
//   err_o          sticky error flag
interface pueo_trig_gate_if #(
    parameter int NBUF     = 16,
    parameter int CNT_BITS = 32
);
    localparam int OUT_BITS = $clog2(NBUF + 1);

    logic                ce_i;
    logic                run_i;
    logic                trig_i;
    logic [15:0]         holdoff_len_i;
    logic                evdone_i;
    logic                holdoff_o;
    logic                dead_o;
    logic [CNT_BITS-1:0] event_num_o;
    logic [OUT_BITS-1:0] outstanding_o;
    logic [CNT_BITS-1:0] deadtime_o;
    logic                err_o;

    modport master (
        output ce_i, run_i, trig_i, holdoff_len_i, evdone_i,
        input  holdoff_o, dead_o, event_num_o, outstanding_o, deadtime_o, err_o
    );

    modport slave (
        input  ce_i, run_i, trig_i, holdoff_len_i, evdone_i,
        output holdoff_o, dead_o, event_num_o, outstanding_o, deadtime_o, err_o
    );
endinterface

// File: rtl/pueo_trig_gate.sv
// pueo_trig_gate
//   Trigger acceptance controller for the level-two trigger path. Accepts
//   master triggers while armed, produces the holdoff and dead gates back to
//   the level-two block, and tracks run state, event numbering, outstanding
//   event buffers and accumulated deadtime.
// Ports:
//   clk_i   system clock
//   rstn_i  asynchronous active-low reset
//   tg      pueo_trig_gate_if.slave: control inputs, gates and status outputs
// All outputs come straight from flops.
module pueo_trig_gate #(
    parameter int NBUF     = 16,
    parameter int CNT_BITS = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    pueo_trig_gate_if.slave  tg
);
    localparam int OUT_BITS = $clog2(NBUF + 1);
    localparam logic [OUT_BITS-1:0] FULL = OUT_BITS'(NBUF);

    localparam logic [1:0] ST_STOP    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [15:0]         hcnt_q, hcnt_d;
    logic [CNT_BITS-1:0] evnum_q, evnum_d;
    logic [CNT_BITS-1:0] dtime_q, dtime_d;
    logic [OUT_BITS-1:0] outst_q, outst_d;
    logic                err_q, err_d;
    logic                holdoff_q;
    logic                dead_q;
    logic                accept;
    logic                dec;
    logic                run_start;

    always_comb begin
        // dead_q already reflects STOP or full buffers for this cycle
        accept    = tg.trig_i && (state_q == ST_ARMED) && !dead_q && tg.run_i;
        dec       = tg.evdone_i && (outst_q != '0);
        run_start = (state_q == ST_STOP) && tg.run_i;

        state_d = state_q;
        hcnt_d  = hcnt_q;
        if (!tg.run_i) begin
            // run drop wins over everything, including a holdoff in progress
            state_d = ST_STOP;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_STOP:  state_d = ST_ARMED;
                ST_ARMED: begin
                    if (accept) begin
                        state_d = ST_HOLDOFF;
                        hcnt_d  = tg.holdoff_len_i;
                    end
                end
                ST_HOLDOFF: begin
                    if (tg.ce_i) begin
                        if (hcnt_q == '0) state_d = ST_ARMED;
                        else              hcnt_d  = hcnt_q - 16'd1;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end

        outst_d = outst_q;
        case ({accept, dec})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        evnum_d = evnum_q;
        if (run_start)   evnum_d = '0;
        else if (accept) evnum_d = evnum_q + 1'b1;

        dtime_d = dtime_q;
        if (run_start)
            dtime_d = '0;
        else if ((state_q != ST_STOP) && tg.ce_i && (holdoff_q || dead_q) && (dtime_q != '1))
            dtime_d = dtime_q + 1'b1;

        // clear on run start, but a same-cycle fault still registers
        err_d = run_start ? 1'b0 : err_q;
        if ((tg.trig_i && !accept) || (tg.evdone_i && (outst_q == '0)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_STOP;
            hcnt_q    <= '0;
            evnum_q   <= '0;
            dtime_q   <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
            holdoff_q <= 1'b0;
            dead_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            evnum_q   <= evnum_d;
            dtime_q   <= dtime_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
            holdoff_q <= (state_d == ST_HOLDOFF);
            dead_q    <= (state_d == ST_STOP) || (outst_d == FULL);
        end
    end

    assign tg.holdoff_o     = holdoff_q;
    assign tg.dead_o        = dead_q;
    assign tg.event_num_o   = evnum_q;
    assign tg.outstanding_o = outst_q;
    assign tg.deadtime_o    = dtime_q;
    assign tg.err_o         = err_q;
endmodule

// File: tb/tb_pueo_trig_gate.sv
// tb_pueo_trig_gate
//   Directed bench for pueo_trig_gate with NBUF=4 and CNT_BITS=4 so that
//   buffer-full, event-number wrap and deadtime saturation are all reachable.
//   Stimulus pushes hand-computed expected snapshots into a queue; a monitor
//   pops and compares them on the falling edge.
module tb_pueo_trig_gate;
    localparam int NBUF     = 4;
    localparam int CNT_BITS = 4;

    localparam int unsigned M_H   = 1;
    localparam int unsigned M_D   = 2;
    localparam int unsigned M_EV  = 4;
    localparam int unsigned M_OUT = 8;
    localparam int unsigned M_DT  = 16;
    localparam int unsigned M_ERR = 32;
    localparam int unsigned M_ALL = 63;

    typedef struct {
        string       name;
        int unsigned mask;
        int unsigned h, d, ev, out, dt, err;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        run_lvl;
    logic [15:0] len;
    exp_t        q[$];
    int          n_checks;
    int          n_err;

    pueo_trig_gate_if #(.NBUF(NBUF), .CNT_BITS(CNT_BITS)) tg_if ();

    pueo_trig_gate #(.NBUF(NBUF), .CNT_BITS(CNT_BITS)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .tg     (tg_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string name, input int unsigned mask,
                              input int unsigned h, input int unsigned d,
                              input int unsigned ev, input int unsigned out,
                              input int unsigned dt, input int unsigned err);
        exp_t e;
        e.name = name; e.mask = mask;
        e.h = h; e.d = d; e.ev = ev; e.out = out; e.dt = dt; e.err = err;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input string field,
                       input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s.%s got %0d expected %0d", name, field, act, exp);
        end
    endtask

    // monitor: compares every queued snapshot at the next falling edge
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if ((e.mask & M_H)   != 0) chk(e.name, "holdoff",     int'(tg_if.holdoff_o),     e.h);
            if ((e.mask & M_D)   != 0) chk(e.name, "dead",        int'(tg_if.dead_o),        e.d);
            if ((e.mask & M_EV)  != 0) chk(e.name, "event_num",   int'(tg_if.event_num_o),   e.ev);
            if ((e.mask & M_OUT) != 0) chk(e.name, "outstanding", int'(tg_if.outstanding_o), e.out);
            if ((e.mask & M_DT)  != 0) chk(e.name, "deadtime",    int'(tg_if.deadtime_o),    e.dt);
            if ((e.mask & M_ERR) != 0) chk(e.name, "err",         int'(tg_if.err_o),         e.err);
        end
    end

    // drive one clock cycle of inputs; returns 1ns after the edge
    task automatic step(input logic ce, input logic trig, input logic done);
        tg_if.ce_i          = ce;
        tg_if.trig_i        = trig;
        tg_if.evdone_i      = done;
        tg_if.run_i         = run_lvl;
        tg_if.holdoff_len_i = len;
        @(posedge clk);
        #1;
        tg_if.ce_i     = 1'b0;
        tg_if.trig_i   = 1'b0;
        tg_if.evdone_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rstn     = 1'b0;
        run_lvl  = 1'b0;
        len      = 16'd0;
        tg_if.ce_i = 1'b0; tg_if.run_i = 1'b0; tg_if.trig_i = 1'b0;
        tg_if.evdone_i = 1'b0; tg_if.holdoff_len_i = 16'd0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        expect_out("reset", M_ALL, 0, 1, 0, 0, 0, 0);

        // arm
        run_lvl = 1'b1;
        step(0, 0, 0);
        expect_out("arm", M_H | M_D | M_EV | M_OUT, 0, 0, 0, 0, 0, 0);

        // holdoff_len=3, ce every 2nd cycle: 4 ce ticks, 8 clocks high
        len = 16'd3;
        step(1, 1, 0);
        expect_out("acc1", M_ALL, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(logic'(i % 2), 0, 0);
            if (i < 7) expect_out("ho_hold", M_H, 1, 0, 0, 0, 0, 0);
            else       expect_out("ho_end", M_ALL, 0, 0, 1, 1, 4, 0);
        end

        // fill all buffers with holdoff_len=0
        len = 16'd0;
        for (int k = 2; k <= 4; k++) begin
            step(0, 1, 0);
            expect_out("acc_fill", M_H | M_D | M_EV | M_OUT, 1, (k == 4) ? 1 : 0, k, k, 0, 0);
            step(1, 0, 0);
            expect_out("ho0_end", M_H | M_D | M_DT, 0, (k == 4) ? 1 : 0, 0, 0, k + 3, 0);
        end
        step(0, 1, 0);
        expect_out("trig_full", M_ALL, 0, 1, 4, 4, 7, 1);
        step(0, 0, 1);
        expect_out("free_full", M_ALL, 0, 0, 4, 3, 7, 1);

        // accept coincident with evdone at outstanding=2
        step(0, 0, 1);
        expect_out("free2", M_D | M_OUT, 0, 0, 0, 2, 0, 0);
        step(0, 1, 1);
        expect_out("coinc", M_ALL, 1, 0, 5, 2, 7, 1);
        step(1, 0, 0);
        expect_out("coinc_end", M_H | M_DT, 0, 0, 0, 0, 8, 0);

        // run dropped two ce ticks into a 10-tick holdoff
        len = 16'd9;
        step(0, 1, 0);
        expect_out("acc_long", M_H | M_EV | M_OUT, 1, 0, 6, 3, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        expect_out("long_2tick", M_H | M_DT, 1, 0, 0, 0, 10, 0);
        run_lvl = 1'b0;
        step(0, 0, 0);
        expect_out("run_drop", M_ALL, 0, 1, 6, 3, 10, 1);
        repeat (3) step(1, 0, 0);
        expect_out("frozen", M_ALL, 0, 1, 6, 3, 10, 1);
        run_lvl = 1'b1;
        step(1, 0, 0);
        expect_out("rerun", M_ALL, 0, 0, 0, 3, 0, 0);

        // event number wrap and deadtime saturation (4-bit counters)
        len = 16'd0;
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 1);
            expect_out("wrap_acc", M_H | M_EV | M_OUT, 1, 0, k % 16, 3, 0, 0);
            step(1, 0, 0);
            expect_out("wrap_ho", M_H | M_DT, 0, 0, 0, 0, (k < 15) ? k : 15, 0);
        end

        // drain, then underflow attempt
        repeat (3) step(0, 0, 1);
        expect_out("drain", M_D | M_OUT | M_ERR, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1);
        expect_out("underflow", M_ALL, 0, 0, 0, 0, 15, 1);

        // asynchronous reset mid-holdoff, pulsed between clock edges
        len = 16'd9;
        step(0, 1, 0);
        expect_out("acc_pre_rst", M_H | M_EV | M_OUT, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0);
        rstn = 1'b0;
        expect_out("async_rst", M_ALL, 0, 1, 0, 0, 0, 0);
        #6 rstn = 1'b1;
        @(posedge clk);
        #1;
        expect_out("rerun_after_rst", M_ALL, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
